pdu_ring_buf: RTL
=================

// Module: pdu_ring_buf
// PURPOSE
// On-chip ring buffer directly downstream of the PDU generator. It absorbs random-address flit
//   writes (a header at the base slot, then data at base+1..base+N) and advances the tail on each commit.
// It returns the base address and the almost-full backpressure.
// It replays each committed PDU in order as a sop/eop-framed 512b stream towards the PCIe DMA engine.
// PARAMETERS
// PDU_AWIDTH      12   slot address width from the shared package; ring holds 2**PDU_AWIDTH flits
// AF_THRESH       64   almost_full asserts when free slots < AF_THRESH (max PDU flits + header + margin)
// LEN_FIFO_DEPTH  64   committed-PDU length queue depth, power of 2
// PORTS
// clk                   in   1           single clock
// rst_n                 in   1           asynchronous active-low reset
// wr_en                 in   1           write strobe from the PDU generator
// wr_addr               in   PDU_AWIDTH  slot address, wraps modulo 2**PDU_AWIDTH
// wr_data               in   flit_lite_t 512b data + sop + eop; data stored, sop/eop ignored
// wr_base_addr          out  PDU_AWIDTH  current tail; next PDU header slot
// almost_full           out  1           write-side backpressure
// update_valid          in   1           commit strobe, one cycle per PDU
// update_size           in   PDU_AWIDTH  data flits in the PDU, excluding header; 0 is legal
// out_data              out  512         flit payload
// out_sop               out  1           first flit (header) of a PDU
// out_eop               out  1           last flit of a PDU
// out_valid             out  1           stream valid
// out_ready             in   1           stream ready
// overflow              out  1           sticky: commit exceeded free space
// BEHAVIOUR
// - Reset (async assert, sync release): tail=0, head=0, used=0, length FIFO empty, out_valid=0, out_sop=0,
//   out_eop=0, out_data=0, overflow=0, almost_full=0, wr_base_addr=0.
// - Writes: wr_en writes wr_data.data to RAM[wr_addr] the same cycle. Writes are never checked
//   against head; the producer honours almost_full.
// - Commit: update_valid -> tail += update_size+1 (mod 2**PDU_AWIDTH) and used += update_size+1.
//   The value update_size is also pushed into the length FIFO. wr_base_addr reflects the new tail on the next cycle.
// - If update_size+1 > free, or the length FIFO is full: set overflow, drop the commit, and leave tail/used unchanged.
// - almost_full = (free < AF_THRESH) | (length FIFO count >= LEN_FIFO_DEPTH-2); registered, 1-cycle lag.
// - used/free: PDU_AWIDTH+1 bit counters, free = 2**PDU_AWIDTH - used.
// - Same-cycle commit and stream release: used += update_size+1-1. Neither event is lost.
// - Read FSM:
//   IDLE: length FIFO non-empty -> pop into rem, go to HDR.
//   HDR: issue read of RAM[head_rd], tag sop=1, eop=(rem==0); if rem==0 go to IDLE, else go to BODY.
//   BODY: issue read, rem-=1, eop=(rem==1); on the last flit go to IDLE (or straight to HDR if another length is ready).
// - A read issues only when a credit is free (2-entry output skid FIFO: occupied + in-flight < 2).
//   The read address head_rd increments per issue and wraps.
// - RAM read latency is 1 cycle into the skid FIFO. out_* is driven from the skid head.
// - The skid FIFO gives full throughput: one flit per cycle while out_ready=1.
// - Stream rules: out_* is held stable while out_valid & !out_ready. Each out_valid&out_ready releases one slot (used-=1).
// - Latency: update_valid in cycle T -> out_valid with out_sop=1 by cycle T+3, given an empty pipe.
// - Order: PDUs are emitted in commit order. Flits within a PDU come from consecutive slots, wrapping at 2**PDU_AWIDTH-1 -> 0.
// - Reset mid-PDU discards all state, including partially streamed PDUs. There is no recovery beyond reset.
// STRUCTURE
// - Shared package: flit_lite_t, PDU_AWIDTH, plus new constants RB_AF_THRESH and RB_LEN_FIFO_DEPTH.
// - Sub-module rb_len_fifo: a synchronous FIFO of PDU_AWIDTH-wide lengths with count output and rst_n.
// - RAM: simple dual-port, inferred, 1-cycle registered read. Do not use reset on the RAM array.
// TESTING
// - Single PDU: 1 header + 3 data writes at 0..3, update_size=3 -> wr_base_addr=4; stream 4 flits.
//   The stream is sop on flit 0, eop on flit 3, data bit-exact; used returns to 0.
// - Header-only: update_size=0 -> one flit with out_sop=1 and out_eop=1; tail advances by 1.
// - Wrap: tail=4094 (PDU_AWIDTH=12), 4-flit PDU written to 4094, 4095, 0, 1 -> streamed in that order; tail=2.
// - Backpressure: 3 PDUs committed, out_ready toggled 1/0 per cycle -> no flit lost or duplicated.
//   out_* stays stable while stalled; sustained out_ready=1 gives 1 flit per cycle.
// - Fill: commit until free < 64 -> almost_full=1. A further commit with update_size+1 > free sets overflow.
//   The state (tail, used) is unchanged.
// - Reset mid-stream: rst_n low while out_valid=1 -> all outputs reach reset values immediately.
//   After release, a new PDU at address 0 streams correctly.

Source files
------------

// File: rtl/pdu_ring_buf_pkg.sv
// Shared types and constants for the PDU ring buffer.
// Flit format, slot address width and ring-buffer sizing defaults.
package pdu_ring_buf_pkg;

  localparam int PDU_AWIDTH        = 12;
  localparam int FLIT_W            = 512;
  localparam int RB_AF_THRESH      = 64;
  localparam int RB_LEN_FIFO_DEPTH = 64;

  typedef struct packed {
    logic [FLIT_W-1:0] data;
    logic              sop;
    logic              eop;
  } flit_lite_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_HDR,
    RD_BODY
  } rd_state_e;

  // Slots occupied by a PDU: its data flits plus the header.
  function automatic logic [PDU_AWIDTH:0] pdu_span(input logic [PDU_AWIDTH-1:0] size);
    return {1'b0, size} + (PDU_AWIDTH+1)'(1);
  endfunction

endpackage

// File: rtl/rb_len_fifo.sv
// Committed-PDU length queue: pop data is combinational from the head, one cycle push-to-visible.
// Push is ignored when full and pop is ignored when empty; the caller checks full/empty first.
module rb_len_fifo
  import pdu_ring_buf_pkg::*;
#(
  parameter int WIDTH = PDU_AWIDTH,
  parameter int DEPTH = RB_LEN_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pdu_ring_buf.sv
// Ring buffer between PDU generator and DMA: random-address flit writes, commit advances tail, in-order sop/eop replay.
// Commit to first flit within 3 cycles; out_ready stalls the 2-entry skid, almost_full throttles the producer.
module pdu_ring_buf
  import pdu_ring_buf_pkg::*;
#(
  parameter int AF_THRESH      = RB_AF_THRESH,
  parameter int LEN_FIFO_DEPTH = RB_LEN_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [PDU_AWIDTH-1:0] wr_addr,
  input  flit_lite_t            wr_data,
  output logic [PDU_AWIDTH-1:0] wr_base_addr,
  output logic                  almost_full,
  input  logic                  update_valid,
  input  logic [PDU_AWIDTH-1:0] update_size,
  output logic [FLIT_W-1:0]     out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow
);

  localparam int                SLOTS      = 1 << PDU_AWIDTH;
  localparam int                LCW        = $clog2(LEN_FIFO_DEPTH) + 1;
  localparam logic [PDU_AWIDTH:0] RING_SLOTS = (PDU_AWIDTH+1)'(SLOTS);
  localparam logic [PDU_AWIDTH:0] AF_LIM     = (PDU_AWIDTH+1)'(AF_THRESH);
  localparam logic [LCW-1:0]    LEN_AF_LIM = LCW'(LEN_FIFO_DEPTH - 2);

  logic [PDU_AWIDTH-1:0] tail;
  logic [PDU_AWIDTH:0]   used;
  logic [PDU_AWIDTH:0]   free;
  logic [PDU_AWIDTH:0]   span;
  logic                  commit_ok;
  logic                  commit_bad;
  logic                  release_flit;

  logic                  len_push;
  logic                  len_pop;
  logic                  len_full;
  logic                  len_empty;
  logic [PDU_AWIDTH-1:0] len_dat;
  logic [LCW-1:0]        len_cnt;

  logic [FLIT_W-1:0]     ram [SLOTS];

  rd_state_e             state;
  rd_state_e             state_n;
  logic [PDU_AWIDTH-1:0] rem;
  logic [PDU_AWIDTH-1:0] rem_n;
  logic [PDU_AWIDTH-1:0] head_rd;
  logic                  issue;
  logic                  iss_sop;
  logic                  iss_eop;
  logic                  credit;

  flit_lite_t            sk_mem [2];
  flit_lite_t            sk_head;
  logic [1:0]            sk_cnt;
  logic                  sk_wp;
  logic                  sk_rp;

  logic                  unused_wr_flags;

  // The generator's framing bits are re-derived from the committed length on replay.
  assign unused_wr_flags = ^{wr_data.sop, wr_data.eop};

  assign free         = RING_SLOTS - used;
  assign span         = pdu_span(update_size);
  assign commit_bad   = update_valid & ((span > free) | len_full);
  assign commit_ok    = update_valid & ~commit_bad;
  assign len_push     = commit_ok;
  assign release_flit = out_valid & out_ready;
  assign wr_base_addr = tail;

  rb_len_fifo #(
    .WIDTH (PDU_AWIDTH),
    .DEPTH (LEN_FIFO_DEPTH)
  ) u_len_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (len_push),
    .push_dat (update_size),
    .pop      (len_pop),
    .pop_dat  (len_dat),
    .full     (len_full),
    .empty    (len_empty),
    .count    (len_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail        <= '0;
      used        <= '0;
      overflow    <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (commit_ok) tail <= tail + span[PDU_AWIDTH-1:0];
      used        <= used + (commit_ok ? span : '0) - (PDU_AWIDTH+1)'(release_flit);
      overflow    <= overflow | commit_bad;
      almost_full <= (free < AF_LIM) | (len_cnt >= LEN_AF_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data.data;
  end

  // A slot freed by this cycle's handshake may be refilled in the same cycle.
  assign credit = (sk_cnt < 2'd2) | release_flit;

  always_comb begin
    state_n = state;
    rem_n   = rem;
    len_pop = 1'b0;
    issue   = 1'b0;
    iss_sop = 1'b0;
    iss_eop = 1'b0;
    case (state)
      RD_IDLE: begin
        if (!len_empty) begin
          len_pop = 1'b1;
          rem_n   = len_dat;
          state_n = RD_HDR;
        end
      end
      RD_HDR: begin
        if (credit) begin
          issue   = 1'b1;
          iss_sop = 1'b1;
          iss_eop = (rem == '0);
          state_n = (rem == '0) ? RD_IDLE : RD_BODY;
        end
      end
      RD_BODY: begin
        if (credit) begin
          issue   = 1'b1;
          iss_eop = (rem == PDU_AWIDTH'(1));
          rem_n   = rem - PDU_AWIDTH'(1);
          if (rem == PDU_AWIDTH'(1)) begin
            if (!len_empty) begin
              len_pop = 1'b1;
              rem_n   = len_dat;
              state_n = RD_HDR;
            end else begin
              state_n = RD_IDLE;
            end
          end
        end
      end
      default: state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RD_IDLE;
      rem     <= '0;
      head_rd <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      if (issue) head_rd <= head_rd + PDU_AWIDTH'(1);
    end
  end

  // The registered RAM read lands directly in the skid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) sk_mem[i] <= '0;
      sk_wp  <= 1'b0;
      sk_rp  <= 1'b0;
      sk_cnt <= '0;
    end else begin
      if (issue) begin
        sk_mem[sk_wp] <= '{data: ram[head_rd], sop: iss_sop, eop: iss_eop};
        sk_wp         <= ~sk_wp;
      end
      if (release_flit) sk_rp <= ~sk_rp;
      sk_cnt <= sk_cnt + 2'(issue) - 2'(release_flit);
    end
  end

  assign sk_head   = sk_mem[sk_rp];
  assign out_valid = (sk_cnt != '0);
  assign out_data  = sk_head.data;
  assign out_sop   = out_valid & sk_head.sop;
  assign out_eop   = out_valid & sk_head.eop;

endmodule
